// File: rtl/bpa_div_seq_if.sv
// Handshake and data bundle for the chained sequential divider: requester
// drives start/abort and the operands, the divider returns result and status.
interface bpa_div_seq_if #(
  parameter int W = 10,
  parameter int N = 48
);
  logic           start;
  logic           abort;
  logic [W-1:0]   a_init;
  logic [N*W-1:0] b;
  logic [W-1:0]   a;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  modport master (
    output start, abort, a_init, b,
    input  a, busy, done, div_by_zero
  );

  modport slave (
    input  start, abort, a_init, b,
    output a, busy, done, div_by_zero
  );
endinterface

// File: rtl/bpa_div_seq.sv
// Divides an accumulator by N divisor terms in turn, one restoring-division
// quotient bit per clock, so a full chain takes exactly N*W cycles.
module bpa_div_seq #(
  parameter int W = 10,
  parameter int N = 48
) (
  input  logic         clk,
  input  logic         rst,
  bpa_div_seq_if.slave bus
);
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [TW-1:0] LAST_TERM = TW'(N - 1);
  localparam logic [BW-1:0] TOP_BIT   = BW'(W - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t         state_q;
  logic [N*W-1:0] b_q;
  logic [W-1:0]   qd_q;
  logic [W-1:0]   rem_q;
  logic [TW-1:0]  term_q;
  logic [BW-1:0]  bit_q;
  logic           zero_q;
  logic [W-1:0]   a_q;
  logic           busy_q;
  logic           done_q;
  logic           dbz_q;

  // One restoring step: the dividend shifts out of qd_q MSB-first while the
  // quotient bits shift in at the bottom, so qd_q ends up holding the quotient.
  logic [W-1:0] dsor;
  logic [W:0]   trial;
  logic [W-1:0] diff;
  logic         q_bit;
  logic [W-1:0] rem_d;
  logic [W-1:0] qd_d;
  logic         zero_d;
  logic         last_bit;
  logic         last_term;

  assign dsor      = b_q[W-1:0];
  assign trial     = {rem_q, qd_q[W-1]};
  assign q_bit     = (trial >= {1'b0, dsor});
  // When q_bit is set the true difference is below dsor, so W bits suffice.
  assign diff      = trial[W-1:0] - dsor;
  assign rem_d     = q_bit ? diff : trial[W-1:0];
  assign qd_d      = {qd_q[W-2:0], q_bit};
  assign zero_d    = zero_q | (dsor == '0);
  assign last_bit  = (bit_q == '0);
  assign last_term = (term_q == LAST_TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      qd_q    <= '0;
      rem_q   <= '0;
      term_q  <= '0;
      bit_q   <= '0;
      zero_q  <= 1'b0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= DIV;
            busy_q  <= 1'b1;
            b_q     <= bus.b;
            qd_q    <= bus.a_init;
            rem_q   <= '0;
            term_q  <= '0;
            bit_q   <= TOP_BIT;
            zero_q  <= 1'b0;
          end
        end
        DIV: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q  <= rem_d;
            qd_q   <= qd_d;
            zero_q <= zero_d;
            if (last_bit) begin
              bit_q <= TOP_BIT;
              if (last_term) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                a_q     <= qd_d;
                dbz_q   <= zero_d;
              end else begin
                // Next term: quotient becomes the new dividend, divisors shift down.
                term_q <= term_q + TW'(1);
                b_q    <= b_q >> W;
                rem_q  <= '0;
              end
            end else begin
              bit_q <= bit_q - BW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a           = a_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_bpa_div_seq.sv
// Scoreboard bench for bpa_div_seq: stimulus queues expected results at each
// accepted start, a monitor pops and checks them on every done pulse.
module tb_bpa_div_seq;
  localparam int W   = 10;
  localparam int N   = 48;
  localparam int LAT = N * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpa_div_seq_if #(.W(W), .N(N)) bus ();
  bpa_div_seq #(.W(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] a;
    logic         dbz;
    int           t0;
    string        name;
  } exp_t;

  exp_t           exp_q[$];
  exp_t           mon_e;
  int             n_cmp  = 0;
  int             n_fail = 0;
  int             cyc    = 0;
  logic [N*W-1:0] bv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  function automatic logic [N*W-1:0] ones_b();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(1);
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_a"}, bus.a, mon_e.a);
        check({mon_e.name, "_dbz"}, bus.div_by_zero, mon_e.dbz);
        check({mon_e.name, "_latency"}, cyc - mon_e.t0, LAT);
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic launch(input string name, input logic [W-1:0] ai,
                        input logic [N*W-1:0] b_in, input bit push,
                        input logic [W-1:0] ea, input logic edbz, input bit ab);
    bus.a_init = ai;
    bus.b      = b_in;
    bus.start  = 1'b1;
    bus.abort  = ab;
    if (push) exp_q.push_back('{a: ea, dbz: edbz, t0: cyc + 1, name: name});
    @(negedge clk);
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.a_init = W'($urandom);
    for (int k = 0; k < N; k++) bus.b[k*W +: W] = W'($urandom);
    check({name, "_busy_after_start"}, bus.busy, 1);
  endtask

  task automatic wait_done(input string name, input bit poke_start);
    int n = 0;
    while (bus.done !== 1'b1 && n < LAT + 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, bus.done, 1);
    if (poke_start) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_done_one_cycle"}, bus.done, 0);
    check({name, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.a_init  = '0;
    bus.b       = '0;
    repeat (3) @(negedge clk);
    check("rst_a", bus.a, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1023 through 48 divisions by 1, with an ignored start mid-chain
    launch("ones", 10'd1023, ones_b(), 1, 10'd1023, 1'b0, 1'b0);
    repeat (48) @(negedge clk);
    bus.a_init = 10'd5;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    check("ones_busy_ignored_start", bus.busy, 1);
    wait_done("ones", 0);

    // 1000/10/4 = 25
    bv = ones_b();
    bv[0*W +: W] = 10'd10;
    bv[1*W +: W] = 10'd4;
    launch("div25", 10'd1000, bv, 1, 10'd25, 1'b0, 1'b0);
    wait_done("div25", 0);

    // Ignored start at cycle 50, abort at cycle 100
    launch("abort", 10'd1023, ones_b(), 0, 10'd0, 1'b0, 1'b0);
    repeat (48) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy_ignored_start", bus.busy, 1);
    repeat (49) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_a_kept", bus.a, 25);
    repeat (LAT) @(negedge clk);
    check("abort_a_still", bus.a, 25);

    // Zero divisor at term 5, launched with abort also high in IDLE
    bv = ones_b();
    bv[5*W +: W] = 10'd0;
    launch("zero5", 10'd512, bv, 1, 10'd1023, 1'b1, 1'b1);
    wait_done("zero5", 0);

    // 1023/3 = 341, /7 = 48, /2 at the last term = 24
    bv = ones_b();
    bv[0*W +: W]     = 10'd3;
    bv[1*W +: W]     = 10'd7;
    bv[(N-1)*W +: W] = 10'd2;
    launch("mixed", 10'd1023, bv, 1, 10'd24, 1'b0, 1'b0);
    wait_done("mixed", 0);

    // Zero on the very last term; start poked during DONE must be ignored
    bv = ones_b();
    bv[(N-1)*W +: W] = 10'd0;
    launch("zero_last", 10'd5, bv, 1, 10'd1023, 1'b1, 1'b0);
    wait_done("zero_last", 1);
    check("done_start_ignored", bus.busy, 0);

    // Asynchronous reset mid-chain
    launch("rstmid", 10'd1023, ones_b(), 0, 10'd0, 1'b0, 1'b0);
    repeat (198) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_a", bus.a, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_done", bus.done, 0);
    check("rstmid_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    bv = ones_b();
    bv[0*W +: W] = 10'd10;
    bv[1*W +: W] = 10'd4;
    launch("after_rst", 10'd1000, bv, 1, 10'd25, 1'b0, 1'b0);
    wait_done("after_rst", 0);

    // Zero dividend with random nonzero divisors
    for (int k = 0; k < N; k++) bv[k*W +: W] = W'($urandom_range(1, 1023));
    launch("zero_dvd", 10'd0, bv, 1, 10'd0, 1'b0, 1'b0);
    wait_done("zero_dvd", 0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
